fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage for the RV32 core. It owns the program counter and issues word requests to the instruction memory port. It buffers returned instructions in a small queue and presents them, with their PC, to the decode stage. It obeys decode's `control_hazard` code and execute's branch/jump redirect, and discards stale in-flight responses after any redirect or flush.

## Interface
- `DATA_W`, default 32: instruction and address width.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `TRAP_VEC`, default 32'h0000_0100: fetch target on decode flush (illegal instruction).
- `DEPTH`, default 2: instruction queue entries; also the maximum number of outstanding requests.

Ports:
- `clk_i`, input, 1: the block's only clock; all state updates on its rising edge.
- `rst_ni`, input, 1: reset, asynchronous and active-low.
- `imem_req_o`, output, 1: fetch request valid.
- `imem_addr_o`, output, DATA_W: fetch address, word aligned.
- `imem_gnt_i`, input, 1: request accepted this cycle.
- `imem_rvalid_i`, input, 1: response valid. Responses return in order, at least 1 cycle after grant.
- `imem_rdata_i`, input, DATA_W: response instruction.
- `control_hazard_i`, input, 2: from decode. 00 = normal, 01 = stall, 11 = flush; 10 is treated as 01.
- `redirect_i`, input, 1: taken branch or jump from execute.
- `redirect_pc_i`, input, DATA_W: redirect target.
- `instr_valid_o`, output, 1: the `instr_o`/`pc_o` pair is valid.
- `instr_o`, output, DATA_W: instruction to decode (`instr_i` of decode).
- `pc_o`, output, DATA_W: PC of `instr_o`.

## Operation
- **State**
  - `pc_q`: next fetch address.
  - Queue of DEPTH {pc, instr} entries, with read/write pointers and a count.
  - `outstanding`: granted requests with no response yet, 0..DEPTH.
  - `discard`: responses still to drop, 0..DEPTH.
- **Request issue**
  - `imem_req_o = rst_ni && (outstanding + count − pop) < DEPTH`, where pop = `instr_valid_o && control_hazard_i == 00`.
  - `imem_addr_o = pc_q`.
  - On grant, `pc_q <= pc_q + 4` and `outstanding` increments. The address may change before grant, but only because of a redirect or flush.
- **Response handling**
  - On `imem_rvalid_i`, `outstanding` decrements.
  - If `discard > 0`, the response is dropped and `discard` decrements.
  - Otherwise {pc of the matching request, `imem_rdata_i`} is pushed. The queue never overflows, by construction of the issue rule.
  - Each entry's PC is tracked by a tag FIFO, or by `pc_q` minus 4 × pending entries.
- **Decode output**
  - `instr_valid_o = count != 0`; `instr_o`/`pc_o` show the queue head.
  - Pop on `control_hazard_i == 00`. On 01 the head holds and fetching continues until the queue plus outstanding requests reach DEPTH.
- **Redirect and flush** (`redirect_i` has priority over flush 11)
  - Next cycle, the queue is emptied.
  - `discard <= outstanding` after this cycle's grant and rvalid have been applied.
  - `pc_q <=` target with bits [1:0] forced to 00. The target is `redirect_pc_i` for a redirect and TRAP_VEC for a flush.
  - A grant in the redirect cycle belongs to the old path and is counted into `discard`.
  - A pop in the redirect cycle is ignored.

## Timing
- Reset values: `imem_req_o` = 0, `imem_addr_o` = RESET_PC, `instr_valid_o` = 0, `instr_o` = 0, `pc_o` = 0. `pc_q` = RESET_PC; queue, `outstanding` and `discard` = 0.
- The first cycle after reset deasserts, `imem_req_o` = 1 with address RESET_PC.
- Latency: grant at cycle N, rvalid at N+1, `instr_valid_o` at N+2 (the queue is registered; there is no bypass).
- Throughput is 1 instruction/cycle with a 1-cycle memory, DEPTH = 2, and no hazards.
- After a redirect or flush in cycle R:
  - `instr_valid_o` = 0 from R+1.
  - The first request to the new target is at R+1.
  - The first new instruction is valid no earlier than R+3.
- Boundary cases:
  - Queue full plus stall: `imem_req_o` = 0 and no entry is lost.
  - Redirect while `discard > 0`: `discard` becomes the current `outstanding`, which already includes the old discards.
  - Simultaneous rvalid and pop with a full queue: legal, and the count is unchanged.
  - Async reset mid-burst: all counters clear and any late responses are undefined to the memory.
  - `pc_q` wraps modulo 2^32.

## Test plan
- **Reset and fetch:** reset release, then 1-cycle memory with `imem_rdata_i` = address. Expect requests to 0x0, 0x4, 0x8…; `instr_valid_o` first at cycle 2 with `pc_o` 0x0; then one instruction per cycle.
- **Stall:** hold `control_hazard_i` = 01 for 5 cycles. Expect the head to stay at pc 0x8, `imem_req_o` to fall after 2 buffered entries, and the sequence to resume without gap or duplicate.
- **Redirect with response in flight:** pulse `redirect_i` with target 0x200 while 1 response is outstanding. Expect the old response dropped, the next request at 0x200, and the first valid `pc_o` = 0x200.
- **Flush:** `control_hazard_i` = 11. Expect the queue cleared and a fetch from 0x100.
- **Redirect beats flush:** redirect to 0x40 and flush in the same cycle. Expect the fetch target to be 0x40.
- **Variable latency:** random 1–4 cycle rvalid and random grant stalls, with random redirects. A scoreboard must see decoded PCs follow the sequential/redirect model with no duplicates or losses, and `outstanding` ≤ DEPTH.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: owns the PC, issues word requests, and buffers in-order
// responses in a small queue for decode; stale responses after a redirect/flush are dropped.
module fetch_stage #(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [DATA_W-1:0] TRAP_VEC = 32'h0000_0100,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              imem_req_o,
    output logic [DATA_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic [1:0]        control_hazard_i,
    input  logic              redirect_i,
    input  logic [DATA_W-1:0] redirect_pc_i,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [DATA_W-1:0] pc_o
);

    localparam int unsigned       CW    = $clog2(DEPTH + 1);
    localparam int unsigned       PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] ALIGN = ~DATA_W'(3);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    logic [DATA_W-1:0]            pc_q, pc_d;
    entry_t [DEPTH-1:0]           q_q;
    // PCs of granted-but-unanswered requests, in grant order
    logic [DEPTH-1:0][DATA_W-1:0] tag_q;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                tag_rd_q, tag_wr_q;
    logic [CW-1:0]                count_q, count_d, outst_q, outst_d, discard_q, discard_d;

    logic        pop_raw, pop, gnt, push, flush, redir_any;
    logic [CW:0] occ;

    assign flush     = (control_hazard_i == 2'b11);
    assign redir_any = redirect_i | flush;
    assign pop_raw   = instr_valid_o && (control_hazard_i == 2'b00);
    assign pop       = pop_raw && !redirect_i;
    assign occ       = {1'b0, outst_q} + {1'b0, count_q} - {{CW{1'b0}}, pop_raw};

    assign imem_req_o  = rst_ni && (occ < (CW+1)'(DEPTH));
    assign imem_addr_o = pc_q;
    assign gnt         = imem_req_o && imem_gnt_i;
    assign push        = imem_rvalid_i && (discard_q == '0);

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = q_q[rd_ptr_q].instr;
    assign pc_o          = q_q[rd_ptr_q].pc;

    always_comb begin
        outst_d   = outst_q + CW'(gnt) - CW'(imem_rvalid_i);
        discard_d = discard_q;
        if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
        // everything still in flight after this cycle belongs to the old path
        if (redir_any) discard_d = outst_d;

        count_d  = count_q + CW'(push) - CW'(pop);
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        if (redir_any) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end

        pc_d = gnt ? pc_q + DATA_W'(4) : pc_q;
        if (redirect_i)  pc_d = redirect_pc_i & ALIGN;
        else if (flush)  pc_d = TRAP_VEC & ALIGN;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q      <= RESET_PC;
            q_q       <= '0;
            tag_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            tag_rd_q  <= '0;
            tag_wr_q  <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            if (gnt) begin
                tag_q[tag_wr_q] <= pc_q;
                tag_wr_q        <= ptr_inc(tag_wr_q);
            end
            if (imem_rvalid_i) tag_rd_q <= ptr_inc(tag_rd_q);
            if (push) begin
                q_q[wr_ptr_q].pc    <= tag_q[tag_rd_q];
                q_q[wr_ptr_q].instr <= imem_rdata_i;
            end
        end
    end

endmodule
